pattern_pwm_mc: RTL and testbench
=================================

# pattern_pwm_mc

Multi-channel, parametrised successor to the single-channel pattern PWM generator. It shifts CH independent PAT_W-bit patterns out in lockstep from one shared sequencer. Features: programmable bit period, repeat count, continuous mode with graceful stop, bit order select and per-channel idle level. It sits between the register/control logic and the output pins, one instance per synchronised output group.

## Interface
- CH, 4, number of output channels (≥1)
- PAT_W, 8, pattern length in bits (≥2)
- RPT_W, 8, repeat-count width
- DIV_W, 16, bit-period divider width
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  run request, sampled only in IDLE
- stop  in  1  graceful stop request, sampled only in RUN
- cont  in  1  1 = repeat until stop, 0 = one-shot of rpt_num+1 patterns
- lsb_first  in  1  1 = bit 0 first, 0 = bit PAT_W-1 first
- bit_div  in  DIV_W  each bit held bit_div+1 cycles
- rpt_num  in  RPT_W  one-shot pattern count minus 1
- pat  in  CH*PAT_W  channel c pattern = pat[c*PAT_W +: PAT_W]
- idle_lvl  in  CH  per-channel output level when not running
- pwm_out  out  CH  registered pattern outputs
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on run completion
- pat_wrap  out  1  one-cycle pulse in last cycle of every pattern

## Operation
- States: IDLE, RUN. Reset → IDLE.
- Reset values: pwm_out=0, busy=0, done=0, pat_wrap=0, all counters 0, stop_pend=0. rst asserted mid-run forces these immediately. No output glitch beyond the async clear.
- IDLE: pwm_out follows idle_lvl, registered, one-cycle latency. start=1 latches cont, lsb_first, bit_div, rpt_num and pat into shadow registers, clears counters and stop_pend, and goes to RUN.
- RUN: all inputs except stop and rst are ignored. Changing config mid-run has no effect.
- Counters:
  - div_cnt counts 0..bit_div.
  - On div_cnt==bit_div it wraps to 0 and bit_idx advances 0..PAT_W-1.
  - On bit_idx==PAT_W-1 it wraps and rpt_cnt increments.
- Channel c output for bit k = shadow pat bit (lsb_first ? k : PAT_W-1-k).
- Pattern boundary is the last cycle of bit PAT_W-1. pat_wrap=1 in that cycle.
- End condition, evaluated at each pattern boundary:
  - one-shot with rpt_cnt==rpt_num, or
  - stop_pend=1, or
  - stop=1 in the boundary cycle itself.
- If the end condition holds → IDLE. Otherwise the next pattern starts with no gap.
- rpt_cnt is compared before incrementing, so rpt_num = all-ones gives 2^RPT_W patterns without overflow.
- stop in RUN sets stop_pend. The run always ends on a pattern boundary, never mid-pattern. stop also applies in one-shot mode.
- stop in IDLE is ignored. start and stop in the same IDLE cycle: run starts, stop is ignored.
- start while busy is ignored; nothing is queued.
- bit_div=0 gives one cycle per bit.

## Timing
- start sampled high at edge of cycle 0. In cycle 1: busy=1, pwm_out=first bit of every channel.
- Bit k occupies cycles 1+k(D+1) .. (k+1)(D+1), where D=bit_div.
- One-shot length L=(R+1)·PAT_W·(D+1), where R=rpt_num. busy=1 in cycles 1..L.
- Cycle L+1: busy=0, done=1, pwm_out=idle_lvl.
- A new start sampled in cycle L+1 gives busy=1 at L+2.
- pat_wrap high in cycles n·PAT_W·(D+1), n=1..R+1.
- stop latency: ends at the first pattern boundary at or after the stop cycle. done follows that boundary by one cycle.

## Test plan
- One-shot, D=0, R=0, MSB-first, ch0 pat=8'hAA, idle_lvl=0 → ch0 = 1,0,1,0,1,0,1,0 in cycles 1–8; busy cycles 1–8; done and pwm_out=0 at cycle 9; pat_wrap at cycle 8.
- D=1, R=2, ch1 pat=8'hCC → each bit 2 cycles; busy cycles 1–48; pat_wrap at 16, 32, 48; done at 49.
- lsb_first=1, D=0, ch2 pat=8'h01, ch3 pat=8'h80 → ch2 high only in cycle 1, ch3 high only in cycle 8; idle_lvl=4'b1111 restores all outputs to 1 at cycle 9.
- cont=1, D=0, stop pulsed at cycle 20 → patterns continue to cycle 24; busy falls and done=1 at cycle 25. A second case pulses stop exactly at cycle 16 → done at 17.
- Robustness:
  - start repeated and pat changed at cycle 3 of a run → output still matches the latched pattern, and run length is unchanged.
  - start+stop together in IDLE → full run.
- rst asserted at cycle 5 of a run → pwm_out, busy, done, pat_wrap = 0 immediately. After release, the next start runs normally from bit 0.

Source files
------------

// File: rtl/pattern_pwm_mc.sv
// pattern_pwm_mc: multi-channel pattern shifter with one shared sequencer.
// Every channel shifts its own PAT_W-bit pattern in lockstep. Bit period,
// repeat count, continuous mode with graceful stop and bit order are
// latched at start. Runs always end on a pattern boundary.
module pattern_pwm_mc #(
  parameter int CH    = 4,
  parameter int PAT_W = 8,
  parameter int RPT_W = 8,
  parameter int DIV_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  cont,
  input  logic                  lsb_first,
  input  logic [DIV_W-1:0]      bit_div,
  input  logic [RPT_W-1:0]      rpt_num,
  input  logic [CH*PAT_W-1:0]   pat,
  input  logic [CH-1:0]         idle_lvl,
  output logic [CH-1:0]         pwm_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pat_wrap
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [RPT_W-1:0]    rpt_cnt_q, rpt_cnt_d;
  logic                stop_pend_q, stop_pend_d;
  logic                done_q, done_d;
  logic [CH-1:0]       pwm_q, pwm_d;

  // Configuration captured at start; the run never looks at the live inputs.
  logic                cont_q, cont_d;
  logic                lsb_q, lsb_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [RPT_W-1:0]    rpt_num_q, rpt_num_d;
  logic [CH*PAT_W-1:0] pat_q, pat_d;

  logic                running;
  logic                div_end;
  logic                bit_end;
  logic                boundary;
  logic                end_run;
  logic [IDX_W-1:0]    next_idx;
  logic [IDX_W-1:0]    next_pos;
  logic                src_lsb;
  logic [CH*PAT_W-1:0] src_pat;
  logic [CH-1:0]       next_bits;

  assign running  = (state_q == S_RUN);
  assign div_end  = (div_cnt_q == div_q);
  assign bit_end  = (bit_idx_q == IDX_LAST);
  assign boundary = running && div_end && bit_end;
  // A stop seen in the boundary cycle itself still ends this pattern.
  assign end_run  = boundary &&
                    ((!cont_q && (rpt_cnt_q == rpt_num_q)) || stop_pend_q || stop);

  // Bit index that will be on the pins next cycle (0 when a run is launched).
  always_comb begin
    next_idx = '0;
    if (running) begin
      if (!div_end)
        next_idx = bit_idx_q;
      else if (!bit_end)
        next_idx = bit_idx_q + IDX_W'(1);
    end
  end

  // At launch the shadows are not loaded yet, so the first bit comes from the inputs.
  assign src_lsb  = running ? lsb_q : lsb_first;
  assign src_pat  = running ? pat_q : pat;
  assign next_pos = src_lsb ? next_idx : (IDX_LAST - next_idx);

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [PAT_W-1:0] ch_pat;
      assign ch_pat        = src_pat[gi*PAT_W +: PAT_W];
      assign next_bits[gi] = ch_pat[next_pos];
    end
  endgenerate

  // Sequencer next-state: launch, counter stepping, end-of-run decision.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_idx_d   = bit_idx_q;
    rpt_cnt_d   = rpt_cnt_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    pwm_d       = pwm_q;
    cont_d      = cont_q;
    lsb_d       = lsb_q;
    div_d       = div_q;
    rpt_num_d   = rpt_num_q;
    pat_d       = pat_q;
    case (state_q)
      S_IDLE: begin
        pwm_d = idle_lvl;
        if (start) begin
          cont_d      = cont;
          lsb_d       = lsb_first;
          div_d       = bit_div;
          rpt_num_d   = rpt_num;
          pat_d       = pat;
          div_cnt_d   = '0;
          bit_idx_d   = '0;
          rpt_cnt_d   = '0;
          stop_pend_d = 1'b0;
          pwm_d       = next_bits;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        pwm_d = next_bits;
        if (stop)
          stop_pend_d = 1'b1;
        if (div_end) begin
          div_cnt_d = '0;
          if (bit_end) begin
            bit_idx_d = '0;
            if (end_run) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              pwm_d   = idle_lvl;
            end else begin
              // Compared before incrementing, so all-ones never overflows early.
              rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, shadows and registered outputs; reset clears all at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      bit_idx_q   <= '0;
      rpt_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      pwm_q       <= '0;
      cont_q      <= 1'b0;
      lsb_q       <= 1'b0;
      div_q       <= '0;
      rpt_num_q   <= '0;
      pat_q       <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_idx_q   <= bit_idx_d;
      rpt_cnt_q   <= rpt_cnt_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      pwm_q       <= pwm_d;
      cont_q      <= cont_d;
      lsb_q       <= lsb_d;
      div_q       <= div_d;
      rpt_num_q   <= rpt_num_d;
      pat_q       <= pat_d;
    end
  end

  assign pwm_out  = pwm_q;
  assign busy     = running;
  assign done     = done_q;
  assign pat_wrap = boundary;

endmodule

// File: tb/tb_pattern_pwm_mc.sv
// Directed bench for pattern_pwm_mc with a per-cycle expectation scoreboard.
module tb_pattern_pwm_mc;

  localparam int CH    = 4;
  localparam int PAT_W = 8;
  localparam int RPT_W = 8;
  localparam int DIV_W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                stop;
  logic                cont;
  logic                lsb_first;
  logic [DIV_W-1:0]    bit_div;
  logic [RPT_W-1:0]    rpt_num;
  logic [CH*PAT_W-1:0] pat;
  logic [CH-1:0]       idle_lvl;
  logic [CH-1:0]       pwm_out;
  logic                busy;
  logic                done;
  logic                pat_wrap;

  typedef struct packed {
    logic [CH-1:0] pwm;
    logic          busy;
    logic          done;
    logic          wrap;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  pattern_pwm_mc #(.CH(CH), .PAT_W(PAT_W), .RPT_W(RPT_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
    .lsb_first(lsb_first), .bit_div(bit_div), .rpt_num(rpt_num), .pat(pat),
    .idle_lvl(idle_lvl), .pwm_out(pwm_out), .busy(busy), .done(done),
    .pat_wrap(pat_wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop one expectation and compare all four outputs against it.
  task automatic pop_compare(input string name, input int t);
    exp_t e;
    if (sb.size() == 0) begin
      check($sformatf("%s_sb_empty_c%0d", name, t), 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check($sformatf("%s_pwm_c%0d", name, t),  32'(pwm_out),  32'(e.pwm));
    check($sformatf("%s_busy_c%0d", name, t), 32'(busy),     32'(e.busy));
    check($sformatf("%s_done_c%0d", name, t), 32'(done),     32'(e.done));
    check($sformatf("%s_wrap_c%0d", name, t), 32'(pat_wrap), 32'(e.wrap));
  endtask

  // Drive one run, predicting cycles 1..L+2 from the timing formulas.
  task automatic run_case(input string name, input logic c_cont, input logic c_lsb,
                          input int d, input int r, input logic [31:0] c_pat,
                          input logic [3:0] c_idle, input int stop_cyc,
                          input bit disturb, input bit stop_with_start);
    int   p;
    int   len;
    int   ls;
    int   off;
    int   k;
    int   pos;
    exp_t e;
    p = PAT_W * (d + 1);
    len = (r + 1) * p;
    if (stop_cyc > 0) begin
      ls = ((stop_cyc + p - 1) / p) * p;
      if (c_cont || ls < len)
        len = ls;
    end
    for (int t = 1; t <= len + 2; t++) begin
      e = '0;
      if (t <= len) begin
        off = (t - 1) % p;
        k   = off / (d + 1);
        pos = c_lsb ? k : (PAT_W - 1 - k);
        for (int c = 0; c < CH; c++)
          e.pwm[c] = c_pat[c*PAT_W + pos];
        e.busy = 1'b1;
        e.wrap = ((t % p) == 0);
      end else begin
        e.pwm  = c_idle;
        e.done = (t == len + 1);
      end
      sb.push_back(e);
    end
    cont      = c_cont;
    lsb_first = c_lsb;
    bit_div   = DIV_W'(d);
    rpt_num   = RPT_W'(r);
    pat       = c_pat;
    idle_lvl  = c_idle;
    tick();
    tick();
    start = 1'b1;
    stop  = stop_with_start;
    tick();
    start = 1'b0;
    for (int t = 1; t <= len + 2; t++) begin
      if (t > 1)
        tick();
      stop = (t == stop_cyc);
      if (disturb && t == 3) begin
        start     = 1'b1;
        pat       = ~c_pat;
        bit_div   = '0;
        rpt_num   = '0;
        lsb_first = ~c_lsb;
        cont      = ~c_cont;
      end
      if (disturb && t == 4)
        start = 1'b0;
      pop_compare(name, t);
    end
    stop = 1'b0;
    $display("case %s done: len=%0d", name, len);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    cont      = 1'b0;
    lsb_first = 1'b0;
    bit_div   = '0;
    rpt_num   = '0;
    pat       = '0;
    idle_lvl  = 4'b1010;
    #1;
    check("reset_pwm",  32'(pwm_out),  32'd0);
    check("reset_busy", 32'(busy),     32'd0);
    check("reset_done", 32'(done),     32'd0);
    check("reset_wrap", 32'(pat_wrap), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_follow", 32'(pwm_out), 32'b1010);

    // One-shot MSB-first, ch0 = AA.
    run_case("oneshot_aa", 1'b0, 1'b0, 0, 0, 32'h0000_00AA, 4'b0000, 0, 1'b0, 1'b0);
    // Two cycles per bit, three patterns, ch1 = CC.
    run_case("div1_rpt2", 1'b0, 1'b0, 1, 2, 32'h0000_CC00, 4'b0000, 0, 1'b0, 1'b0);
    // LSB-first, ch2 = 01, ch3 = 80, idle all ones.
    run_case("lsb_first", 1'b0, 1'b1, 0, 0, 32'h8001_0000, 4'b1111, 0, 1'b0, 1'b0);
    // Continuous mode, stop mid-pattern and exactly on a boundary.
    run_case("cont_stop20", 1'b1, 1'b0, 0, 0, 32'h5A3C_96F0, 4'b0000, 20, 1'b0, 1'b0);
    run_case("cont_stop16", 1'b1, 1'b0, 0, 0, 32'h5A3C_96F0, 4'b0101, 16, 1'b0, 1'b0);
    // Stop during a one-shot still ends on a boundary.
    run_case("oneshot_stop", 1'b0, 1'b1, 0, 5, 32'h1234_5678, 4'b0000, 11, 1'b0, 1'b0);
    // Config churn and repeated start mid-run are ignored.
    run_case("disturb", 1'b0, 1'b0, 2, 1, 32'hC3A5_0FE1, 4'b0011, 0, 1'b1, 1'b0);
    // start and stop together in IDLE: full run.
    run_case("start_stop", 1'b0, 1'b0, 0, 1, 32'h00FF_A55A, 4'b0000, 0, 1'b0, 1'b1);
    // Maximum repeat count: 256 patterns.
    run_case("rpt_max", 1'b0, 1'b1, 0, 255, 32'h6B2D_71E4, 4'b1001, 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a run.
    cont      = 1'b0;
    lsb_first = 1'b0;
    bit_div   = '0;
    rpt_num   = '0;
    pat       = 32'h0000_00FF;
    idle_lvl  = 4'b0000;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 2; t <= 5; t++)
      tick();
    check("pre_rst_pwm",  32'(pwm_out), 32'b0001);
    check("pre_rst_busy", 32'(busy),    32'd1);
    rst = 1'b1;
    #1;
    check("midrst_pwm",  32'(pwm_out),  32'd0);
    check("midrst_busy", 32'(busy),     32'd0);
    check("midrst_done", 32'(done),     32'd0);
    check("midrst_wrap", 32'(pat_wrap), 32'd0);
    tick();
    rst = 1'b0;
    run_case("after_rst", 1'b0, 1'b0, 0, 0, 32'h0000_00AA, 4'b0000, 0, 1'b0, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
